// File: rtl/dmem_bus_ctrl_if.sv
// External data-bus bundle between dmem_bus_ctrl (master) and data memory (slave).
// Single req/ack transaction: request held stable until a one-cycle ack pulse.
interface dmem_bus_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ack;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        output bus_ack,
        output bus_rdata
    );
endinterface

// File: rtl/dmem_bus_ctrl.sv
// Data-memory stage: turns core load/store strobes into req/ack bus transactions.
// Latency: stall = k+1 cycles for an ack k cycles after bus_req rises, then one DONE cycle.
// Backpressure: stall holds the core while a request is pending; optional DMEM_TIMEOUT_EN aborts stuck requests.
module dmem_bus_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic              mem_we_i,
    input  logic              mem_re_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              stall_o,
    output logic              err_o,
    dmem_bus_ctrl_if.master   bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic access;
    logic aligned;

    assign access  = mem_we_i | mem_re_i;
    assign aligned = (mem_addr_i[1:0] == 2'b00);

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timed_out;

    assign timed_out = (cnt_q == CNT_LAST);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT > 0);
`endif

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef DMEM_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    if (aligned) begin
                        addr_d  = {mem_addr_i[ADDR_W-1:2], 2'b00};
                        wdata_d = mem_wdata_i;
                        we_d    = mem_we_i;
                        req_d   = 1'b1;
                        state_d = ST_REQ;
`ifdef DMEM_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        // Misaligned access never reaches the bus.
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_REQ: begin
                if (bus.bus_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_DONE;
                    if (!we_q) begin
                        rdata_d = bus.bus_rdata;
                    end
`ifdef DMEM_TIMEOUT_EN
                end else if (timed_out) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    rdata_d = DATA_W'(32'hDEADBEEF);
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

`ifdef DMEM_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // DONE releases the core even though its strobes are still presented.
    assign stall_o = ((state_q == ST_IDLE) && access) || (state_q == ST_REQ);

    assign mem_rdata_o   = rdata_q;
    assign err_o         = err_q;
    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Bench for dmem_bus_ctrl: directed and random load/store traffic against a word-memory model.
// Runs with or without DMEM_TIMEOUT_EN; the timeout steps only exist when the macro is defined.
module tb_dmem_bus_ctrl;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_rdata;
    logic          stall;
    logic          err;

    always #5 clk = ~clk;

    dmem_bus_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

    dmem_bus_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .mem_addr_i  (mem_addr),
        .mem_wdata_i (mem_wdata),
        .mem_we_i    (mem_we),
        .mem_re_i    (mem_re),
        .mem_rdata_o (mem_rdata),
        .stall_o     (stall),
        .err_o       (err),
        .bus         (bus_if)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem_model [logic [31:0]];
    logic        exp_err;
    logic [31:0] exp_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete core access: presents strobes in IDLE, acts as memory, checks through DONE.
    // ack_k = REQ cycle (1-based) carrying the ack; 0 = never ack.
    task automatic access(input logic we, input logic re, input logic [31:0] addr,
                          input logic [31:0] wdata, input int ack_k);
        int          req_cycles   = 0;
        int          stall_cycles = 0;
        bit          done         = 0;
        bit          mis;
        int          exp_stall;
        int          exp_reqs;
        logic [31:0] rd;
        mis = (addr[1:0] != 2'b00);
        @(negedge clk);
        mem_we = we; mem_re = re; mem_addr = addr; mem_wdata = wdata;
        bus_if.bus_ack = 1'b0;
        #1;
        chk("idle_req_low", bus_if.bus_req, 1'b0);
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            if (cyc > 0) begin
                @(negedge clk);
                bus_if.bus_ack   = 1'b0;
                bus_if.bus_rdata = $urandom;
                #1;
            end
            if (!stall) begin
                done = 1;
            end else begin
                stall_cycles++;
                if (bus_if.bus_req) begin
                    req_cycles++;
                    chk("req_we", bus_if.bus_we, we);
                    chk("req_addr", bus_if.bus_addr, addr);
                    chk("req_wdata", bus_if.bus_wdata, wdata);
                    if (req_cycles == ack_k) begin
                        rd = mem_model.exists(addr) ? mem_model[addr] : $urandom;
                        bus_if.bus_ack   = 1'b1;
                        bus_if.bus_rdata = rd;
                        if (we) mem_model[addr] = wdata;
                        else    exp_rdata = rd;
                    end
                end
            end
        end
        chk("done_reached", done, 1'b1);
        if (mis) begin
            exp_stall = 1; exp_reqs = 0; exp_err = 1'b1; exp_rdata = 32'h0;
        end else if (ack_k == 0) begin
            exp_stall = TMO + 1; exp_reqs = TMO; exp_err = 1'b1; exp_rdata = 32'hDEADBEEF;
        end else begin
            exp_stall = ack_k + 1; exp_reqs = ack_k;
        end
        chk("stall_cycles", stall_cycles, exp_stall);
        chk("req_cycles", req_cycles, exp_reqs);
        chk("done_req_low", bus_if.bus_req, 1'b0);
        chk("done_rdata", mem_rdata, exp_rdata);
        chk("done_err", err, exp_err);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mem_we = 1'b0; mem_re = 1'b0;
            #1;
            chk("idle_stall", stall, 1'b0);
            chk("idle_req", bus_if.bus_req, 1'b0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        mem_addr = '0; mem_wdata = '0; mem_we = 1'b0; mem_re = 1'b0;
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0;
        exp_err = 1'b0; exp_rdata = 32'h0;
        #1;
        chk("rst_req", bus_if.bus_req, 1'b0);
        chk("rst_we", bus_if.bus_we, 1'b0);
        chk("rst_addr", bus_if.bus_addr, 32'h0);
        chk("rst_wdata", bus_if.bus_wdata, 32'h0);
        chk("rst_rdata", mem_rdata, 32'h0);
        chk("rst_err", err, 1'b0);
        chk("rst_stall", stall, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // Aligned store, ack on third REQ cycle.
        access(1'b1, 1'b0, 32'h100, 32'hCAFEF00D, 3);
        idle(1);
        // Aligned load, zero-wait ack.
        mem_model[32'h204] = 32'h12345678;
        access(1'b0, 1'b1, 32'h204, 32'h0, 1);
        idle(1);
        // Misaligned load, then err stays set through a good load.
        access(1'b0, 1'b1, 32'h203, 32'h0, 1);
        idle(1);
        access(1'b0, 1'b1, 32'h100, 32'h0, 2);
        idle(1);

        // Asynchronous reset while a load sits in REQ.
        @(negedge clk);
        mem_we = 1'b0; mem_re = 1'b1; mem_addr = 32'h500;
        @(negedge clk);
        #1;
        chk("pre_rst_req", bus_if.bus_req, 1'b1);
        mem_re = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("async_rst_req", bus_if.bus_req, 1'b0);
        chk("async_rst_err", err, 1'b0);
        chk("async_rst_rdata", mem_rdata, 32'h0);
        exp_err = 1'b0; exp_rdata = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h0BAD0BAD;
        #1;
        chk("post_rst_stall", stall, 1'b0);
        @(negedge clk);
        bus_if.bus_ack = 1'b0;
        #1;
        chk("spurious_ack_req", bus_if.bus_req, 1'b0);
        chk("spurious_ack_rdata", mem_rdata, 32'h0);
        chk("spurious_ack_err", err, 1'b0);

        // Store wins over load, then back-to-back load of the same word.
        access(1'b1, 1'b1, 32'h300, 32'hA5A55A5A, 2);
        access(1'b0, 1'b1, 32'h300, 32'h0, 1);
        idle(1);

`ifdef DMEM_TIMEOUT_EN
        access(1'b0, 1'b1, 32'h400, 32'h0, 0);
        idle(1);
        mem_model[32'h404] = 32'h600DF00D;
        access(1'b0, 1'b1, 32'h404, 32'h0, TMO);
        idle(1);
`endif

        for (int n = 0; n < 24; n++) begin
            logic        r_we;
            logic        r_re;
            logic [31:0] r_addr;
            r_we   = 1'($urandom_range(0, 1));
            r_re   = r_we ? 1'($urandom_range(0, 1)) : 1'b1;
            r_addr = 32'h1000 + (32'($urandom_range(0, 7)) << 2);
            if ($urandom_range(0, 7) == 0) r_addr = r_addr + 32'($urandom_range(1, 3));
            access(r_we, r_re, r_addr, $urandom, int'($urandom_range(1, 5)));
            if ($urandom_range(0, 1) == 1) idle(1);
        end
        idle(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_bus_ctrl.md
Name: dmem_bus_ctrl

Overview:
- Data-memory stage directly downstream of the single-cycle core.
- Consumes the core's data-side outputs: ALU result as address, register read port 2 as write data, and the memory write strobe. A read strobe comes from the core's load-select control.
- Runs a req/ack transaction on the external data bus.
- Returns load data to the core, and holds the core with a stall while a transaction is outstanding.

Parameters:
- ADDR_W, 32, width of CPU and bus byte address
- DATA_W, 32, data word width
- TIMEOUT, 16, cycles in REQ without bus_ack before abort (used only with DMEM_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- mem_addr  in  ADDR_W  byte address from the core's ALU result
- mem_wdata  in  DATA_W  store data from the core's register read port 2
- mem_we  in  1  store strobe from the core
- mem_re  in  1  load strobe from the core's result-select control
- mem_rdata  out  DATA_W  load data to the core's result mux
- stall  out  1  core must hold PC and suppress register write while high
- bus_req  out  1  transaction request, registered
- bus_we  out  1  1 = write, 0 = read, registered
- bus_addr  out  ADDR_W  registered, word aligned
- bus_wdata  out  DATA_W  registered
- bus_ack  in  1  single-cycle completion pulse from memory
- bus_rdata  in  DATA_W  valid in the cycle bus_ack is high
- err  out  1  sticky fault flag

Behaviour:
- Reset (reset low, async) takes effect immediately, including mid-transaction:
  - state = IDLE
  - bus_req = 0, bus_we = 0, bus_addr = 0, bus_wdata = 0
  - mem_rdata register = 0, err = 0
- States: IDLE, REQ, DONE.
- IDLE:
  - If mem_we or mem_re is high and mem_addr[1:0] == 0: latch the address, latch mem_wdata, and set bus_we = mem_we (a store wins if both are high). Set bus_req = 1 and go to REQ.
  - If an access is requested with mem_addr[1:0] != 0: set err = 1 and issue no bus transaction. Load the rdata register with 0 and go to DONE.
  - With no access requested, remain in IDLE.
- REQ:
  - bus_req, bus_we, bus_addr and bus_wdata stay stable until bus_ack.
  - On bus_ack: bus_req = 0. For reads, capture bus_rdata into the rdata register. Go to DONE.
  - Any bus_ack in IDLE or DONE is ignored.
- DONE: lasts one cycle, then unconditionally returns to IDLE. The core's access is still presented this cycle, and IDLE re-evaluates the next instruction's strobes on the following cycle.
- stall (combinational):
  - High when the state is IDLE and (mem_we | mem_re) is high.
  - High in REQ.
  - Low in DONE, and low in IDLE with no access.
- mem_rdata is driven from the rdata register at all times. Its value is meaningful to the core only in the DONE cycle of a load.
- Latency: with an ack arriving k cycles after bus_req rises, stall is high for k+1 cycles. A zero-wait ack (k = 1) therefore gives 2 stall cycles, followed by DONE.
- err is sticky. Only reset clears it.
- Back-to-back accesses: bus_req drops for at least the DONE cycle and the following IDLE cycle.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments each cycle in REQ.
  - When it reaches TIMEOUT with no bus_ack: drop bus_req, set err = 1, load rdata with 32'hDEADBEEF and go to DONE.
  - If bus_ack and the timeout fall in the same cycle, the ack wins.
- Undefined: no counter exists, and REQ waits indefinitely for bus_ack.

Test Plan:
- Aligned store (mem_we=1, addr=0x100, wdata=0xCAFEF00D), ack 3 cycles after req -> bus_req/bus_we=1 with bus_addr=0x100 and bus_wdata=0xCAFEF00D held stable; stall high 4 cycles then low 1 cycle; err=0.
- Aligned load (mem_re=1, addr=0x204), ack on first REQ cycle with bus_rdata=0x12345678 -> mem_rdata=0x12345678 in DONE; stall pattern 1,1,0.
- Misaligned load at addr=0x203 -> bus_req never asserts; stall 1 cycle; mem_rdata=0 in DONE; err=1 and remains 1 through later good accesses.
- Reset pulse low while in REQ -> bus_req=0 immediately (asynchronously); next cycle IDLE; spurious bus_ack afterwards ignored; err=0.
- Both mem_we and mem_re high, followed immediately by a second load -> first transaction is a write; bus_req is low for 2 cycles between transactions; second transaction is a read.
- With DMEM_TIMEOUT_EN and TIMEOUT=16, load with no ack -> abort after 16 REQ cycles; mem_rdata=0xDEADBEEF in DONE; err=1. Repeat with ack in cycle 16 -> real data returned and err unchanged.
